// File: rtl/verificador_paridad_serie_if.sv
// Purpose: bus bundle between the XOR stage, the serial parity checker and
//          the downstream consumer.
// Signals: EntradaValida/EntradaBit/InicioTrama (serial side, into the checker),
//          DatoSalida/SalidaValida/ErrorParidad/ContadorErrores/Ocupado (report side),
//          ContadorAbortos only when VERIFICADOR_PARIDAD_ABORTOS_EN is defined.
// Modports: slave = checker, master = producer/consumer environment.
interface verificador_paridad_serie_if #(
  parameter int unsigned ANCHO_DATOS    = 8,
  parameter int unsigned ANCHO_CONTADOR = 8
);
  logic                      EntradaValida;
  logic                      EntradaBit;
  logic                      InicioTrama;
  logic [ANCHO_DATOS-1:0]    DatoSalida;
  logic                      SalidaValida;
  logic                      ErrorParidad;
  logic [ANCHO_CONTADOR-1:0] ContadorErrores;
  logic                      Ocupado;
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
  logic [ANCHO_CONTADOR-1:0] ContadorAbortos;
`endif

  modport slave (
    input  EntradaValida, EntradaBit, InicioTrama,
    output DatoSalida, SalidaValida, ErrorParidad, ContadorErrores, Ocupado
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
    , output ContadorAbortos
`endif
  );

  modport master (
    output EntradaValida, EntradaBit, InicioTrama,
    input  DatoSalida, SalidaValida, ErrorParidad, ContadorErrores, Ocupado
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
    , input ContadorAbortos
`endif
  );
endinterface

// File: rtl/verificador_paridad_serie.sv
// Purpose: serial parity checker. Deserialises ANCHO_DATOS data bits (LSB
//          first) plus one parity bit, reports the word with a one-cycle
//          SalidaValida pulse, flags parity mismatches and keeps a saturating
//          count of erroneous frames.
// Ports:   Reloj  - clock, rising edge
//          Reset  - asynchronous, active-high
//          bus    - verificador_paridad_serie_if.slave (serial input, report outputs)
// Option:  VERIFICADOR_PARIDAD_ABORTOS_EN adds a saturating ContadorAbortos
//          output counting frames discarded by a new InicioTrama.
module verificador_paridad_serie #(
  parameter int unsigned ANCHO_DATOS    = 8,
  parameter int unsigned ANCHO_CONTADOR = 8,
  parameter int unsigned PARIDAD_IMPAR  = 0
) (
  input  logic                           Reloj,
  input  logic                           Reset,
  verificador_paridad_serie_if.slave     bus
);

  localparam int unsigned ANCHO_CUENTA = $clog2(ANCHO_DATOS + 1);
  localparam logic        BIT_IMPAR    = 1'(PARIDAD_IMPAR);
  localparam logic [ANCHO_CONTADOR-1:0] CONT_MAX = {ANCHO_CONTADOR{1'b1}};

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    DATOS   = 2'd1,
    PARIDAD = 2'd2
  } estado_t;

  estado_t                   estado_q, estado_d;
  logic [ANCHO_DATOS-1:0]    desp_q, desp_d;
  logic [ANCHO_CUENTA-1:0]   cuenta_q, cuenta_d;
  logic                      acc_q, acc_d;
  logic [ANCHO_DATOS-1:0]    dato_q, dato_d;
  logic                      valida_q, valida_d;
  logic                      error_q, error_d;
  logic [ANCHO_CONTADOR-1:0] cont_err_q, cont_err_d;
  logic                      ocupado_q, ocupado_d;
  logic                      err_c;
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
  logic [ANCHO_CONTADOR-1:0] cont_ab_q, cont_ab_d;
`endif

  // State and output registers
  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      estado_q   <= REPOSO;
      desp_q     <= '0;
      cuenta_q   <= '0;
      acc_q      <= 1'b0;
      dato_q     <= '0;
      valida_q   <= 1'b0;
      error_q    <= 1'b0;
      cont_err_q <= '0;
      ocupado_q  <= 1'b0;
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
      cont_ab_q  <= '0;
`endif
    end else begin
      estado_q   <= estado_d;
      desp_q     <= desp_d;
      cuenta_q   <= cuenta_d;
      acc_q      <= acc_d;
      dato_q     <= dato_d;
      valida_q   <= valida_d;
      error_q    <= error_d;
      cont_err_q <= cont_err_d;
      ocupado_q  <= ocupado_d;
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
      cont_ab_q  <= cont_ab_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    estado_d   = estado_q;
    desp_d     = desp_q;
    cuenta_d   = cuenta_q;
    acc_d      = acc_q;
    dato_d     = dato_q;
    valida_d   = 1'b0;
    error_d    = error_q;
    cont_err_d = cont_err_q;
    err_c      = acc_q ^ bus.EntradaBit ^ BIT_IMPAR;
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
    cont_ab_d  = cont_ab_q;
`endif

    if (bus.EntradaValida) begin
      if (bus.InicioTrama) begin
        // A start marker always (re)starts a frame; mid-frame it is an abort.
        // Bits enter at the MSB and shift down, so after ANCHO_DATOS bits the
        // first one sits at bit 0.
        estado_d = DATOS;
        desp_d   = {bus.EntradaBit, (ANCHO_DATOS-1)'(0)};
        acc_d    = bus.EntradaBit;
        cuenta_d = ANCHO_CUENTA'(1);
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
        if ((estado_q != REPOSO) && (cont_ab_q != CONT_MAX))
          cont_ab_d = cont_ab_q + ANCHO_CONTADOR'(1);
`endif
      end else begin
        case (estado_q)
          DATOS: begin
            desp_d   = {bus.EntradaBit, desp_q[ANCHO_DATOS-1:1]};
            acc_d    = acc_q ^ bus.EntradaBit;
            cuenta_d = cuenta_q + ANCHO_CUENTA'(1);
            if (cuenta_q == ANCHO_CUENTA'(ANCHO_DATOS - 1))
              estado_d = PARIDAD;
          end
          PARIDAD: begin
            estado_d = REPOSO;
            valida_d = 1'b1;
            dato_d   = desp_q;
            error_d  = err_c;
            cuenta_d = '0;
            acc_d    = 1'b0;
            if (err_c && (cont_err_q != CONT_MAX))
              cont_err_d = cont_err_q + ANCHO_CONTADOR'(1);
          end
          default: ;  // REPOSO: bits without a start marker are dropped
        endcase
      end
    end

    ocupado_d = (estado_d != REPOSO);
  end

  assign bus.DatoSalida      = dato_q;
  assign bus.SalidaValida    = valida_q;
  assign bus.ErrorParidad    = error_q;
  assign bus.ContadorErrores = cont_err_q;
  assign bus.Ocupado         = ocupado_q;
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
  assign bus.ContadorAbortos = cont_ab_q;
`endif

endmodule

// File: tb/tb_verificador_paridad_serie.sv
// Purpose: self-checking bench for verificador_paridad_serie. Two instances
//          share the serial stimulus: one with default parameters and one with
//          a 2-bit error counter to exercise saturation.
module tb_verificador_paridad_serie;

  localparam int unsigned W     = 8;
  localparam int unsigned CW0   = 8;
  localparam int unsigned CW1   = 2;
  localparam int unsigned IMPAR = 0;

  logic clk;
  logic rst;
  logic v, b, s;

  int total;
  int passed;
  int nerr;     // erroneous frames reported since last reset
  int nab;      // aborted frames since last reset

  verificador_paridad_serie_if #(.ANCHO_DATOS(W), .ANCHO_CONTADOR(CW0)) bus0 ();
  verificador_paridad_serie_if #(.ANCHO_DATOS(W), .ANCHO_CONTADOR(CW1)) bus1 ();

  assign bus0.EntradaValida = v;
  assign bus0.EntradaBit    = b;
  assign bus0.InicioTrama   = s;
  assign bus1.EntradaValida = v;
  assign bus1.EntradaBit    = b;
  assign bus1.InicioTrama   = s;

  verificador_paridad_serie #(.ANCHO_DATOS(W), .ANCHO_CONTADOR(CW0), .PARIDAD_IMPAR(IMPAR)) u0 (
    .Reloj (clk),
    .Reset (rst),
    .bus   (bus0)
  );

  verificador_paridad_serie #(.ANCHO_DATOS(W), .ANCHO_CONTADOR(CW1), .PARIDAD_IMPAR(IMPAR)) u1 (
    .Reloj (clk),
    .Reset (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish (obs=timeout exp=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int sat(input int n, input int bits);
    int mx;
    mx = (1 << bits) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // One valid bit, sampled at the next rising edge; returns at the following
  // falling edge with random don't-care values on the qualified inputs.
  task automatic put(input logic bit_v, input logic st);
    v = 1'b1; b = bit_v; s = st;
    @(negedge clk);
    v = 1'b0; b = 1'($urandom); s = 1'($urandom);
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      v = 1'b0; b = 1'($urandom); s = 1'($urandom);
      @(negedge clk);
    end
  endtask

  // Sends word w with parity p and checks the report one clock after parity.
  task automatic frame(input logic [W-1:0] w, input logic p, input bit gaps);
    logic e;
    for (int i = 0; i < int'(W); i++) begin
      if (gaps) bubble(int'($urandom_range(0, 2)));
      put(w[i], i == 0);
      chk("no_pulse_mid_frame", 32'(bus0.SalidaValida), 32'(0));
      if (i == 3) chk("ocupado_mid_frame", 32'(bus0.Ocupado), 32'(1));
    end
    if (gaps) bubble(int'($urandom_range(0, 2)));
    put(p, 1'b0);
    e = ((($countones(w) + int'(p) + int'(IMPAR)) % 2) != 0);
    if (e) nerr++;
    chk("pulse",       32'(bus0.SalidaValida),    32'(1));
    chk("dato",        32'(bus0.DatoSalida),      32'(w));
    chk("error",       32'(bus0.ErrorParidad),    32'(e));
    chk("cont_err",    32'(bus0.ContadorErrores), 32'(sat(nerr, CW0)));
    chk("cont_err_2b", 32'(bus1.ContadorErrores), 32'(sat(nerr, CW1)));
    chk("pulse_2b",    32'(bus1.SalidaValida),    32'(1));
    chk("ocupado_end", 32'(bus0.Ocupado),         32'(0));
`ifdef VERIFICADOR_PARIDAD_ABORTOS_EN
    chk("cont_abortos", 32'(bus0.ContadorAbortos), 32'(sat(nab, CW0)));
`endif
  endtask

  task automatic idle_check(input logic [W-1:0] last_w);
    bubble(1);
    chk("pulse_one_cycle", 32'(bus0.SalidaValida), 32'(0));
    chk("dato_hold",       32'(bus0.DatoSalida),   32'(last_w));
  endtask

  initial begin
    logic [W-1:0] w;
    logic         p;
    total = 0; passed = 0; nerr = 0; nab = 0;
    v = 1'b0; b = 1'b0; s = 1'b0;
    rst = 1'b1;

    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_valida",  32'(bus0.SalidaValida),    32'(0));
      chk("idle_ocupado", 32'(bus0.Ocupado),         32'(0));
      chk("idle_dato",    32'(bus0.DatoSalida),      32'(0));
      chk("idle_error",   32'(bus0.ErrorParidad),    32'(0));
      chk("idle_cont",    32'(bus0.ContadorErrores), 32'(0));
    end
    // Valid bits without a start marker are dropped
    for (int i = 0; i < 3; i++) begin
      put(1'($urandom), 1'b0);
      chk("drop_ocupado", 32'(bus0.Ocupado),      32'(0));
      chk("drop_valida",  32'(bus0.SalidaValida), 32'(0));
    end

    // Basic frames
    frame(8'hA5, 1'b0, 1'b0);
    idle_check(8'hA5);
    frame(8'h07, 1'b0, 1'b0);
    idle_check(8'h07);

    // Gapped frame immediately followed by another
    frame(8'h3C, 1'b0, 1'b1);
    frame(8'hFF, 1'b0, 1'b0);
    idle_check(8'hFF);

    // Abort after 4 bits, restart with 0x81
    put(1'b1, 1'b1);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    put(1'b1, 1'b0);
    nab++;
    frame(8'h81, 1'b0, 1'b0);
    idle_check(8'h81);

    // Saturation of the 2-bit counter: five erroneous frames after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nerr = 0; nab = 0;
    bubble(2);
    for (int k = 0; k < 5; k++) begin
      w = W'($urandom);
      p = 1'(($countones(w) + 1 + int'(IMPAR)) % 2);
      frame(w, p, 1'b0);
    end
    idle_check(w);

    // Reset asserted mid-frame during bit 5
    for (int i = 0; i < 5; i++) put(1'($urandom), i == 0);
    v = 1'b1; b = 1'($urandom); s = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_dato",    32'(bus0.DatoSalida),      32'(0));
    chk("rst_valida",  32'(bus0.SalidaValida),    32'(0));
    chk("rst_error",   32'(bus0.ErrorParidad),    32'(0));
    chk("rst_cont",    32'(bus0.ContadorErrores), 32'(0));
    chk("rst_cont_2b", 32'(bus1.ContadorErrores), 32'(0));
    chk("rst_ocupado", 32'(bus0.Ocupado),         32'(0));
    @(negedge clk);
    v = 1'b0;
    rst = 1'b0;
    nerr = 0; nab = 0;
    bubble(1);
    chk("post_rst_valida", 32'(bus0.SalidaValida), 32'(0));
    frame(8'h5A, 1'b1, 1'b0);
    idle_check(8'h5A);

    // Randomised frames, gaps, back-to-back and occasional aborts
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, W)); i++)
          put(1'($urandom), i == 0);
        nab++;
      end
      w = W'($urandom);
      p = 1'($urandom);
      frame(w, p, 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_check(w);
    end
    bubble(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/verificador_paridad_serie.md
Name: verificador_paridad_serie

Overview:
Serial parity checker placed directly downstream of the bitwise XOR stage, which delivers one bit per valid cycle.
- Deserialises a frame of ANCHO_DATOS data bits, LSB first, followed by one parity bit.
- Accumulates the running XOR of the frame and checks it against the received parity bit.
- Presents the parallel word, an error flag and a saturating error count to the next stage.

Parameters:
ANCHO_DATOS, 8, data bits per frame (legal range 2..32).
ANCHO_CONTADOR, 8, width of the saturating error counter.
PARIDAD_IMPAR, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
Reloj  input  1  single clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
EntradaValida  input  1  qualifies EntradaBit and InicioTrama; ignored when 0.
EntradaBit  input  1  serial bit coming from the XOR stage.
InicioTrama  input  1  sampled only with EntradaValida; marks the first data bit of a frame.
DatoSalida  output  ANCHO_DATOS  received word; bit 0 = first data bit.
SalidaValida  output  1  one-cycle pulse: DatoSalida and ErrorParidad are valid.
ErrorParidad  output  1  1 = parity mismatch on the frame just reported.
ContadorErrores  output  ANCHO_CONTADOR  saturating count of frames with ErrorParidad = 1.
Ocupado  output  1  1 while a frame is in progress (states DATOS and PARIDAD).

Behaviour:
- Reset (async, any state, including mid-frame):
  - State = REPOSO.
  - DatoSalida = 0, SalidaValida = 0, ErrorParidad = 0, ContadorErrores = 0, Ocupado = 0.
  - Shift register, bit counter and XOR accumulator cleared; any partial frame is discarded.
- States: REPOSO, DATOS, PARIDAD. Every transition requires EntradaValida = 1; with EntradaValida = 0 all state holds (bubbles allowed anywhere in a frame).
- REPOSO:
  - EntradaValida & InicioTrama: capture EntradaBit as data bit 0, set acc = EntradaBit, set count = 1, go to DATOS.
  - Valid bits without InicioTrama are dropped.
- DATOS:
  - Each valid bit is stored at position count, acc ^= bit, count++.
  - When the bit stored is bit ANCHO_DATOS-1, go to PARIDAD.
- PARIDAD:
  - The next valid bit is the parity bit p.
  - err = acc ^ p ^ PARIDAD_IMPAR.
  - Return to REPOSO.
- Output timing:
  - In the cycle after p is sampled: SalidaValida = 1 for exactly one cycle, DatoSalida = received word, ErrorParidad = err.
  - DatoSalida and ErrorParidad hold until the next report.
  - Latency from parity-bit edge to SalidaValida: 1 clock.
- Counter: if err = 1, ContadorErrores increments in the same cycle that SalidaValida rises; it saturates at all-ones and never wraps.
- Abort: InicioTrama = 1 with EntradaValida while in DATOS or PARIDAD discards the partial frame (no SalidaValida) and restarts as if in REPOSO, with this bit as data bit 0.
- Back-to-back frames: InicioTrama is accepted in the cycle immediately after the parity bit. The new frame starts while the previous SalidaValida pulse is being driven; the two do not interfere.
- No backpressure: the consumer must accept each SalidaValida pulse.

Optional Feature:
VERIFICADOR_PARIDAD_ABORTOS_EN
- Defined:
  - Adds output port ContadorAbortos [ANCHO_CONTADOR-1:0].
  - Reset value 0; increments once per abort as defined above; saturates at all-ones.
- Undefined: the port and its logic are absent; abort behaviour is otherwise identical.

Test Plan:
- Reset release, idle 10 cycles -> all outputs 0, Ocupado = 0, no SalidaValida.
- Frame 0xA5 LSB first plus parity 0 (defaults) -> 1 cycle after parity: SalidaValida pulse, DatoSalida = 0xA5, ErrorParidad = 0, ContadorErrores = 0.
- Frame 0x07 plus parity 0 (odd count of ones) -> ErrorParidad = 1, ContadorErrores = 1.
- 0x3C with random EntradaValida gaps, immediately followed by 0xFF; each frame with parity 0 -> two pulses, DatoSalida 0x3C then 0xFF, both ErrorParidad = 0.
- 4 bits sent, then InicioTrama with new frame 0x81/parity 0 -> single pulse with 0x81, no error. With _EN defined: ContadorAbortos = 1.
- ANCHO_CONTADOR = 2, five erroneous frames -> ContadorErrores sequence 1, 2, 3, 3, 3.
- Reset asserted mid-frame at bit 5 -> outputs clear immediately, no pulse; next full frame decodes correctly.
